// File: rtl/updown_seq_pkg.sv
// Shared constants for the up/down sequencing controller: FSM state encoding and
// direction line values.
package updown_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updown_step_cnt.sv
// Up/down counter datapath owned by the sequencing controller: steps by +1 or -1
// (modulo 2^WIDTH) on every enabled clock.
module updown_step_cnt
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = (up == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequencing controller: accepts a target via valid/ready and steps the owned counter
// one count per prescaled tick toward it. Define UPDOWN_SEQ_WRAP_EN for shortest-path wrap.
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_target,
  output logic             req_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_en;
  logic [WIDTH-1:0] step_val;

  function automatic logic pick_dir(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] cur);
`ifdef UPDOWN_SEQ_WRAP_EN
    logic [WIDTH-1:0] up_dist;
    logic [WIDTH-1:0] half;
    up_dist = tgt - cur;
    half    = {1'b1, {(WIDTH-1){1'b0}}};
    // A tie at exactly half the range resolves upward.
    return (up_dist <= half) ? DIR_UP : DIR_DN;
`else
    return (tgt > cur) ? DIR_UP : DIR_DN;
`endif
  endfunction

  updown_step_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (step_en),
    .up  (dir_q),
    .q   (q)
  );

  // Value the counter will hold after this cycle's step, used to detect arrival on the same edge.
  assign step_val = (dir_q == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pre_d    = pre_q;
    step_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          dir_d    = pick_dir(req_target, q);
          pre_d    = '0;
          if (req_target == q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over a due tick so the counter never moves on the abort edge.
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          step_en = 1'b1;
          if (step_val == target_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      pre_q    <= '0;
      dir_q    <= DIR_UP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pre_q    <= pre_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
